keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl_if.sv | 43 ++++
 rtl/keypad_entry_ctrl.sv | 140 ++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry controller bus: encoder inputs, control keys and timer handshake.
// The master modport drives keys/encoder data; the slave modport is the controller.
interface keypad_entry_ctrl_if;
    logic [3:0]  enc_bcd;
    logic        enc_valid;
    logic        start_key;
    logic        clear_key;
    logic        run_done;
    logic        enc_en;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        load;
    logic        abort;
    logic        busy;

    modport master (
        output enc_bcd,
        output enc_valid,
        output start_key,
        output clear_key,
        output run_done,
        input  enc_en,
        input  digits,
        input  digit_cnt,
        input  load,
        input  abort,
        input  busy
    );

    modport slave (
        input  enc_bcd,
        input  enc_valid,
        input  start_key,
        input  clear_key,
        input  run_done,
        output enc_en,
        output digits,
        output digit_cnt,
        output load,
        output abort,
        output busy
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects up to four BCD digits, starts/aborts a countdown timer.
// Optional press debounce is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic                clk,
    input logic                rst,
    keypad_entry_ctrl_if.slave kp
);

    typedef enum logic [1:0] {StIdle, StPress, StRelease, StRun} state_e;

    state_e      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  pending_q, pending_d;
    logic        enc_en_q;
    logic        load;
    logic        abort;
    logic        commit;

    if (DEBOUNCE_CYCLES == 0) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DbW-1:0] db_q, db_d;
`endif

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        load      = 1'b0;
        abort     = 1'b0;
        commit    = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
        db_d      = db_q;
`endif

        if (kp.clear_key) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = StIdle;
            abort    = (state_q == StRun);
`ifdef KEYPAD_DEBOUNCE_EN
            db_d     = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (kp.start_key && cnt_q != 3'd0) begin
                        load    = 1'b1;
                        state_d = StRun;
                    end else if (kp.enc_valid && kp.enc_bcd <= 4'd9) begin
                        pending_d = kp.enc_bcd;
                        state_d   = StPress;
`ifdef KEYPAD_DEBOUNCE_EN
                        db_d      = '0;
`endif
                    end
                end
                StPress: begin
`ifdef KEYPAD_DEBOUNCE_EN
                    if (kp.enc_valid && kp.enc_bcd == pending_q) begin
                        if (int'(db_q) + 1 >= int'(DEBOUNCE_CYCLES)) begin
                            commit  = 1'b1;
                            state_d = StRelease;
                            db_d    = '0;
                        end else begin
                            db_d = db_q + 1'b1;
                        end
                    end else begin
                        // Bounce or key change before the count completes: abandon the press.
                        state_d = StIdle;
                        db_d    = '0;
                    end
`else
                    commit  = 1'b1;
                    state_d = StRelease;
`endif
                end
                StRelease: begin
                    if (!kp.enc_valid) begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    if (kp.run_done) begin
                        digits_d = '0;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end
                end
            endcase
        end

        // A fifth digit is swallowed so the displayed time never shifts out a digit.
        if (commit && cnt_q < 3'd4) begin
            digits_d = {digits_q[11:0], pending_q};
            cnt_d    = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            digits_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            enc_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            enc_en_q  <= (state_d != StRun);
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q <= '0;
        end else begin
            db_q <= db_d;
        end
    end
`endif

    assign kp.enc_en    = enc_en_q;
    assign kp.digits    = digits_q;
    assign kp.digit_cnt = cnt_q;
    assign kp.load      = load;
    assign kp.abort     = abort;
    assign kp.busy      = (state_q == StRun);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios then random keys, checked each cycle
// against an event-level model holding the entered digits in a queue.
module tb_keypad_entry_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_entry_ctrl_if kp ();

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int checks = 0;
    int errors = 0;

    localparam int KeyFree     = 0;
    localparam int KeyCaptured = 1;
    localparam int KeyHeld     = 2;

    int unsigned m_q[$];
    int          m_key;
    int unsigned m_pending;
    bit          m_run;
    bit          m_enc_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_digits();
        int unsigned d = 0;
        foreach (m_q[i]) d = d * 16 + m_q[i];
        return d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_key     = KeyFree;
        m_pending = 0;
        m_run     = 1'b0;
        m_enc_en  = 1'b0;
    endtask

    task automatic check_model();
        bit exp_load;
        bit exp_abort;
        exp_load  = !kp.clear_key && !m_run && m_key == KeyFree && kp.start_key && m_q.size() > 0;
        exp_abort = kp.clear_key && m_run;
        chk("digits", kp.digits, model_digits());
        chk("digit_cnt", kp.digit_cnt, m_q.size());
        chk("enc_en", kp.enc_en, m_enc_en);
        chk("busy", kp.busy, m_run);
        chk("load", kp.load, exp_load);
        chk("abort", kp.abort, exp_abort);
    endtask

    task automatic model_step();
        if (kp.clear_key) begin
            m_q.delete();
            m_run = 1'b0;
            m_key = KeyFree;
        end else if (m_run) begin
            if (kp.run_done) begin
                m_q.delete();
                m_run = 1'b0;
            end
        end else if (m_key == KeyCaptured) begin
            if (m_q.size() < 4) m_q.push_back(m_pending);
            m_key = KeyHeld;
        end else if (m_key == KeyHeld) begin
            if (!kp.enc_valid) m_key = KeyFree;
        end else if (kp.start_key && m_q.size() > 0) begin
            m_run = 1'b1;
        end else if (kp.enc_valid && kp.enc_bcd <= 4'd9) begin
            m_pending = kp.enc_bcd;
            m_key     = KeyCaptured;
        end
        m_enc_en = !m_run;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] bcd, input int hold, input int rel);
        kp.enc_valid = 1'b1;
        kp.enc_bcd   = bcd;
        repeat (hold) cycle();
        kp.enc_valid = 1'b0;
        repeat (rel) cycle();
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_digits"}, kp.digits, 0);
        chk({tag, "_cnt"}, kp.digit_cnt, 0);
        chk({tag, "_enc_en"}, kp.enc_en, 0);
        chk({tag, "_busy"}, kp.busy, 0);
        chk({tag, "_load"}, kp.load, 0);
        chk({tag, "_abort"}, kp.abort, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        kp.enc_bcd   = '0;
        kp.enc_valid = 1'b0;
        kp.start_key = 1'b0;
        kp.clear_key = 1'b0;
        kp.run_done  = 1'b0;
        model_reset();
        #1;
        chk("reset_digits", kp.digits, 0);
        chk("reset_enc_en", kp.enc_en, 0);
        chk("reset_busy", kp.busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        chk("first_edge_enc_en", kp.enc_en, 1);

        // Four digits fill the display; a fifth is discarded.
        press(4'd1, 3, 2);
        press(4'd2, 3, 2);
        press(4'd3, 3, 2);
        press(4'd0, 3, 2);
        chk("four_digits", kp.digits, 16'h1230);
        chk("four_cnt", kp.digit_cnt, 4);
        press(4'd7, 3, 2);
        chk("fifth_dropped", kp.digits, 16'h1230);
        chk("fifth_cnt", kp.digit_cnt, 4);

        // Long hold commits once.
        kp.clear_key = 1'b1;
        cycle();
        kp.clear_key = 1'b0;
        press(4'd5, 20, 2);
        chk("hold_digits", kp.digits, 16'h0005);
        chk("hold_cnt", kp.digit_cnt, 1);

        // Non-decimal code is dropped.
        press(4'hB, 3, 2);
        chk("bad_bcd_cnt", kp.digit_cnt, 1);

        // Start, run, ignored key, done.
        kp.clear_key = 1'b1;
        cycle();
        kp.clear_key = 1'b0;
        press(4'd1, 3, 2);
        press(4'd3, 3, 2);
        press(4'd0, 3, 2);
        chk("run_digits", kp.digits, 16'h0130);
        kp.start_key = 1'b1;
        #2;
        chk("start_load", kp.load, 1);
        cycle();
        kp.start_key = 1'b0;
        chk("run_busy", kp.busy, 1);
        chk("run_enc_en", kp.enc_en, 0);
        chk("run_hold_digits", kp.digits, 16'h0130);
        press(4'd9, 3, 2);
        chk("run_key_ignored", kp.digits, 16'h0130);
        kp.run_done = 1'b1;
        cycle();
        kp.run_done = 1'b0;
        chk("done_digits", kp.digits, 0);
        chk("done_busy", kp.busy, 0);
        chk("done_enc_en", kp.enc_en, 1);

        // Clear beats run_done in RUN; start with no digits is ignored.
        press(4'd4, 3, 2);
        kp.start_key = 1'b1;
        cycle();
        kp.start_key = 1'b0;
        kp.clear_key = 1'b1;
        kp.run_done  = 1'b1;
        #2;
        chk("clear_abort", kp.abort, 1);
        chk("clear_no_load", kp.load, 0);
        cycle();
        kp.clear_key = 1'b0;
        kp.run_done  = 1'b0;
        chk("clear_digits", kp.digits, 0);
        chk("clear_busy", kp.busy, 0);
        kp.start_key = 1'b1;
        #2;
        chk("empty_start_load", kp.load, 0);
        cycle();
        kp.start_key = 1'b0;
        chk("empty_start_busy", kp.busy, 0);

        // Asynchronous reset mid-press and mid-run.
        kp.enc_valid = 1'b1;
        kp.enc_bcd   = 4'd6;
        cycle();
        async_reset("rst_press");
        kp.enc_valid = 1'b0;
        cycle();
        chk("rst_press_no_commit", kp.digit_cnt, 0);
        press(4'd2, 3, 2);
        kp.start_key = 1'b1;
        cycle();
        kp.start_key = 1'b0;
        async_reset("rst_run");
        cycle();

        // Random keys, controls and timer completions.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                kp.enc_valid = ($urandom_range(0, 2) != 0);
                kp.enc_bcd   = 4'($urandom_range(0, 15));
            end
            kp.start_key = ($urandom_range(0, 7) == 0);
            kp.clear_key = ($urandom_range(0, 39) == 0);
            kp.run_done  = m_run && ($urandom_range(0, 5) == 0);
            cycle();
        end
        kp.enc_valid = 1'b0;
        kp.start_key = 1'b0;
        kp.clear_key = 1'b0;
        kp.run_done  = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
